// File: rtl/rf_pkg.sv
// Shared register-file definitions: sweep FSM encoding and default geometry,
// also used by the decode/issue logic.
package rf_pkg;

    localparam int RF_XLEN  = 32;
    localparam int RF_DEPTH = 32;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } rf_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, set wins on a
// same-address collision, clear-all wins over both.
module rf_scoreboard #(
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_set,
    input  logic [AW-1:0]     i_set_a,
    input  logic              i_clr,
    input  logic [AW-1:0]     i_clr_a,
    input  logic              i_clr_all,
    input  logic [NRD*AW-1:0] i_ra,
    output logic [NRD-1:0]    o_busy
);

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_next;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_bit
            if (ZERO_REG && gi == 0) begin : g_zero
                assign w_busy_next[gi] = 1'b0;
            end else begin : g_live
                assign w_busy_next[gi] = i_clr_all                            ? 1'b0 :
                                         (i_set && i_set_a == AW'(gi))        ? 1'b1 :
                                         (i_clr && i_clr_a == AW'(gi))        ? 1'b0 :
                                                                                r_busy[gi];
            end
        end

        for (gi = 0; gi < NRD; gi++) begin : g_look
            assign o_busy[gi] = r_busy[i_ra[gi*AW +: AW]];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with optional write bypass, busy scoreboard
// and a zeroing sweep that runs after reset or on clr_req.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NRD      = 2,
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                iss,
    input  logic [AW-1:0]       iss_a,
    input  logic                clr_req,
    output logic                ready
);

    rf_state_e       r_state;
    rf_state_e       w_state_next;
    logic [AW-1:0]   r_ptr;
    logic [AW-1:0]   w_ptr_next;
    logic            w_clr_all;
    logic            w_ready;

    logic [XLEN-1:0] r_mem [DEPTH];
    logic            w_mem_we;
    logic [AW-1:0]   w_mem_wa;
    logic [XLEN-1:0] w_mem_wd;
    logic            w_wa_zero;
    logic [NRD-1:0]  w_sb_busy;

    assign w_ready = (r_state == ST_IDLE);
    assign ready   = w_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SWEEP;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // clr_req during the sweep restarts it, even on its final step.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_clr_all    = 1'b0;
        case (r_state)
            ST_SWEEP: begin
                if (clr_req) begin
                    w_ptr_next = '0;
                end else if (r_ptr == AW'(DEPTH - 1)) begin
                    w_state_next = ST_IDLE;
                    w_ptr_next   = '0;
                end else begin
                    w_ptr_next = r_ptr + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_next = ST_SWEEP;
                    w_ptr_next   = '0;
                    w_clr_all    = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_SWEEP;
                w_ptr_next   = '0;
            end
        endcase
    end

    // Single array write port, shared between the sweep and writeback.
    assign w_wa_zero = ZERO_REG && (wa == '0);
    assign w_mem_we  = (r_state == ST_SWEEP) || (we && w_ready && !w_wa_zero);
    assign w_mem_wa  = (r_state == ST_SWEEP) ? r_ptr : wa;
    assign w_mem_wd  = (r_state == ST_SWEEP) ? '0 : wd;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_wa] <= w_mem_wd;
        end
    end

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .i_set     (iss && w_ready),
        .i_set_a   (iss_a),
        .i_clr     (we && w_ready),
        .i_clr_a   (wa),
        .i_clr_all (w_clr_all),
        .i_ra      (ra),
        .o_busy    (w_sb_busy)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] w_ra;
            logic          w_hit;
            logic          w_zero;

            assign w_ra   = ra[gi*AW +: AW];
            assign w_zero = ZERO_REG && (w_ra == '0);
            assign w_hit  = BYPASS && we && (wa == w_ra);

            assign rd[gi*XLEN +: XLEN] = (!w_ready || w_zero) ? '0 :
                                         w_hit                ? wd :
                                                                r_mem[w_ra];

            // A forwarded value is not busy unless a new producer issues now.
            assign rbusy[gi] = (!w_ready || w_zero) ? 1'b0 :
                               w_hit                ? (iss && (iss_a == w_ra)) :
                                                      w_sb_busy[gi];
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised and directed checks of reg_file_mp (bypass and non-bypass builds)
// against an array/counter reference model.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ra;
    logic [63:0] rd_b, rd_n;
    logic [1:0]  rbusy_b, rbusy_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iss;
    logic [4:0]  iss_a;
    logic        clr_req;
    logic        ready_b, ready_n;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem_m [32];
    bit          busy_m [32];
    bit          ready_m;
    int          cnt_m;

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(32), .DEPTH(32), .NRD(2), .BYPASS(1'b1), .ZERO_REG(1'b1)) u_byp (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_b), .rbusy(rbusy_b), .we(we), .wa(wa), .wd(wd),
        .iss(iss), .iss_a(iss_a), .clr_req(clr_req), .ready(ready_b)
    );

    reg_file_mp #(.XLEN(32), .DEPTH(32), .NRD(2), .BYPASS(1'b0), .ZERO_REG(1'b1)) u_nob (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_n), .rbusy(rbusy_n), .we(we), .wa(wa), .wd(wd),
        .iss(iss), .iss_a(iss_a), .clr_req(clr_req), .ready(ready_n)
    );

    function automatic void model_reset();
        cnt_m   = 0;
        ready_m = 1'b0;
        for (int i = 0; i < 32; i++) begin
            busy_m[i] = 1'b0;
            mem_m[i]  = 32'h0;
        end
    endfunction

    // One clock edge of the specified behaviour, using the inputs held across it.
    function automatic void model_update();
        if (!ready_m) begin
            if (cnt_m < 32) mem_m[cnt_m] = 32'h0;
            if (clr_req) begin
                cnt_m = 0;
            end else begin
                cnt_m++;
                if (cnt_m == 32) ready_m = 1'b1;
            end
        end else begin
            if (we && wa != 0) mem_m[wa] = wd;
            if (we) busy_m[wa] = 1'b0;
            if (iss && iss_a != 0) busy_m[iss_a] = 1'b1;
            if (clr_req) begin
                ready_m = 1'b0;
                cnt_m   = 0;
                for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
            end
        end
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (!ready_m || a == 0) return 32'h0;
        if (byp && we && wa == a) return wd;
        return mem_m[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        if (!ready_m || a == 0) return 1'b0;
        if (byp && we && wa == a) return iss && (iss_a == a);
        return busy_m[a];
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we = 1'b0; wa = '0; wd = '0; iss = 1'b0; iss_a = '0; clr_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ra  = '0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        n_vec++;
        if (ready_b !== 1'b0 || ready_n !== 1'b0 || rd_b !== 64'h0 || rbusy_b !== 2'b00) begin
            n_err++;
            $display("FAIL reset_state: ready=%b/%b rd=%h rbusy=%b, required ready=0 rd=0 rbusy=0",
                     ready_b, ready_n, rd_b, rbusy_b);
        end
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            n_vec++;
            if (ready_b !== (k == 32) || ready_n !== (k == 32)) begin
                n_err++;
                $display("FAIL sweep_ready edge %0d: ready=%b/%b required %b", k, ready_b, ready_n, k == 32);
            end
        end
        for (int a = 0; a < 32; a++) begin
            ra = {5'(31 - a), 5'(a)};
            #1;
            n_vec++;
            if (rd_b !== 64'h0 || rd_n !== 64'h0) begin
                n_err++;
                $display("FAIL swept_zero addr %0d/%0d: rd=%h/%h required 0", a, 31 - a, rd_b, rd_n);
            end
        end
    endtask

    task automatic test_write_zero();
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra = {5'd0, 5'd5};
        step();
        we = 1'b0;
        #1;
        n_vec++;
        if (rd_b[31:0] !== 32'hDEADBEEF || rd_n[31:0] !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL write_read r5: rd0=%h/%h required deadbeef", rd_b[31:0], rd_n[31:0]);
        end
        we = 1'b1; wa = 5'd0; wd = 32'h1234;
        #1;
        n_vec++;
        if (rd_b[63:32] !== 32'h0) begin
            n_err++;
            $display("FAIL zero_reg_bypass: rd1=%h required 0", rd_b[63:32]);
        end
        step();
        we = 1'b0;
        #1;
        n_vec++;
        if (rd_b[63:32] !== 32'h0 || rd_n[63:32] !== 32'h0) begin
            n_err++;
            $display("FAIL zero_reg_write: rd1=%h/%h required 0", rd_b[63:32], rd_n[63:32]);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; ra = {5'd5, 5'd7};
        #1;
        n_vec++;
        if (rd_b[31:0] !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL bypass_on: rd0=%h required a5a5a5a5", rd_b[31:0]);
        end
        n_vec++;
        if (rd_n[31:0] !== 32'h0) begin
            n_err++;
            $display("FAIL bypass_off_old: rd0=%h required 00000000", rd_n[31:0]);
        end
        step();
        we = 1'b0;
        #1;
        n_vec++;
        if (rd_n[31:0] !== 32'hA5A5A5A5 || rd_b[31:0] !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL bypass_after: rd0=%h/%h required a5a5a5a5", rd_b[31:0], rd_n[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        iss = 1'b1; iss_a = 5'd9; ra = {5'd0, 5'd9};
        #1;
        n_vec++;
        if (rbusy_b[0] !== 1'b0) begin
            n_err++;
            $display("FAIL busy_not_early: rbusy0=%b required 0", rbusy_b[0]);
        end
        step();
        iss = 1'b0;
        #1;
        n_vec++;
        if (rbusy_b[0] !== 1'b1 || rbusy_n[0] !== 1'b1) begin
            n_err++;
            $display("FAIL busy_set: rbusy0=%b/%b required 1", rbusy_b[0], rbusy_n[0]);
        end
        we = 1'b1; wa = 5'd9; wd = 32'h99;
        #1;
        n_vec++;
        if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b1) begin
            n_err++;
            $display("FAIL busy_fwd: rbusy0=%b/%b required 0/1", rbusy_b[0], rbusy_n[0]);
        end
        step();
        we = 1'b0;
        #1;
        n_vec++;
        if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b0) begin
            n_err++;
            $display("FAIL busy_clear: rbusy0=%b/%b required 0", rbusy_b[0], rbusy_n[0]);
        end
        iss = 1'b1; iss_a = 5'd9; we = 1'b1; wa = 5'd9; wd = 32'h12345678;
        #1;
        n_vec++;
        if (rbusy_b[0] !== 1'b1 || rbusy_n[0] !== 1'b0) begin
            n_err++;
            $display("FAIL busy_collide_now: rbusy0=%b/%b required 1/0", rbusy_b[0], rbusy_n[0]);
        end
        step();
        idle_inputs();
        #1;
        n_vec++;
        if (rbusy_b[0] !== 1'b1 || rbusy_n[0] !== 1'b1 || rd_b[31:0] !== 32'h12345678 ||
            rd_n[31:0] !== 32'h12345678) begin
            n_err++;
            $display("FAIL busy_collide: rbusy0=%b/%b rd0=%h/%h required 1 and 12345678",
                     rbusy_b[0], rbusy_n[0], rd_b[31:0], rd_n[31:0]);
        end
        iss = 1'b1; iss_a = 5'd0;
        step();
        iss = 1'b0;
        #1;
        n_vec++;
        if (rbusy_b[1] !== 1'b0 || rbusy_n[1] !== 1'b0) begin
            n_err++;
            $display("FAIL busy_zero_reg: rbusy1=%b/%b required 0", rbusy_b[1], rbusy_n[1]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            ra      = 10'($urandom);
            we      = 1'($urandom);
            wa      = 5'($urandom);
            wd      = $urandom;
            iss     = 1'($urandom);
            iss_a   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            clr_req = ($urandom_range(0, 59) == 0);
            #1;
            n_vec++;
            if (ready_b !== ready_m || ready_n !== ready_m) begin
                n_err++;
                $display("FAIL rand_ready cyc %0d: ready=%b/%b required %b", c, ready_b, ready_n, ready_m);
            end
            for (int p = 0; p < 2; p++) begin
                n_vec++;
                if (rd_b[p*32 +: 32] !== exp_rd(ra[p*5 +: 5], 1'b1) ||
                    rd_n[p*32 +: 32] !== exp_rd(ra[p*5 +: 5], 1'b0)) begin
                    n_err++;
                    $display("FAIL rand_rd cyc %0d port %0d ra=%0d: rd=%h/%h required %h/%h", c, p,
                             ra[p*5 +: 5], rd_b[p*32 +: 32], rd_n[p*32 +: 32],
                             exp_rd(ra[p*5 +: 5], 1'b1), exp_rd(ra[p*5 +: 5], 1'b0));
                end
                n_vec++;
                if (rbusy_b[p] !== exp_busy(ra[p*5 +: 5], 1'b1) ||
                    rbusy_n[p] !== exp_busy(ra[p*5 +: 5], 1'b0)) begin
                    n_err++;
                    $display("FAIL rand_busy cyc %0d port %0d ra=%0d: rbusy=%b/%b required %b/%b", c, p,
                             ra[p*5 +: 5], rbusy_b[p], rbusy_n[p],
                             exp_busy(ra[p*5 +: 5], 1'b1), exp_busy(ra[p*5 +: 5], 1'b0));
                end
            end
            step();
        end
        idle_inputs();
        for (int w = 0; w < 40 && !ready_m; w++) step();
        #1;
        n_vec++;
        if (ready_b !== 1'b1 || ready_n !== 1'b1) begin
            n_err++;
            $display("FAIL rand_recover: ready=%b/%b required 1", ready_b, ready_n);
        end
    endtask

    task automatic test_clear();
        we = 1'b1; wa = 5'd3; wd = 32'h55;
        step();
        we = 1'b0; iss = 1'b1; iss_a = 5'd4;
        step();
        iss = 1'b0; ra = {5'd4, 5'd3};
        #1;
        n_vec++;
        if (rd_b[31:0] !== 32'h55 || rbusy_b[1] !== 1'b1) begin
            n_err++;
            $display("FAIL clr_setup: rd0=%h rbusy1=%b required 00000055 and 1", rd_b[31:0], rbusy_b[1]);
        end
        clr_req = 1'b1;
        step();
        clr_req = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'hFFFF; iss = 1'b1; iss_a = 5'd4;
        for (int k = 1; k <= 32; k++) begin
            #1;
            n_vec++;
            if (ready_b !== 1'b0 || ready_n !== 1'b0 || rd_b !== 64'h0 || rbusy_b !== 2'b00) begin
                n_err++;
                $display("FAIL clr_sweep cyc %0d: ready=%b/%b rd=%h rbusy=%b required all 0",
                         k, ready_b, ready_n, rd_b, rbusy_b);
            end
            step();
        end
        idle_inputs();
        #1;
        n_vec++;
        if (ready_b !== 1'b1 || rd_b[31:0] !== 32'h0 || rd_n[31:0] !== 32'h0 ||
            rbusy_b[1] !== 1'b0 || rbusy_n[1] !== 1'b0) begin
            n_err++;
            $display("FAIL clr_done: ready=%b rd0=%h/%h rbusy1=%b/%b required 1, 0, 0",
                     ready_b, rd_b[31:0], rd_n[31:0], rbusy_b[1], rbusy_n[1]);
        end
    endtask

    task automatic test_rst_mid_sweep();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        model_reset();
        #2;
        n_vec++;
        if (ready_b !== 1'b0 || rbusy_b !== 2'b00) begin
            n_err++;
            $display("FAIL rst_mid: ready=%b rbusy=%b required 0", ready_b, rbusy_b);
        end
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            step();
            n_vec++;
            if (ready_b !== (k == 32) || ready_n !== (k == 32)) begin
                n_err++;
                $display("FAIL rst_resweep edge %0d: ready=%b/%b required %b", k, ready_b, ready_n, k == 32);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_zero();
        test_bypass();
        test_scoreboard();
        test_random();
        test_clear();
        test_rst_mid_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
